// File: rtl/dict_loader_if.sv
// Memory read port and dictionary write ports of the boot-time dictionary loader.
interface dict_loader_if #(
    parameter int unsigned FIELD1_VAL_WIDTH = 7,
    parameter int unsigned FIELD2_VAL_WIDTH = 10,
    parameter int unsigned FIELD3_VAL_WIDTH = 15
);
    logic                        mem_req_valid;
    logic                        mem_req_ready;
    logic [31:0]                 mem_req_addr;
    logic [31:0]                 mem_req_rdata;
    logic                        dict1_write_enable;
    logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val;
    logic                        dict2_write_enable;
    logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val;
    logic                        dict3_write_enable;
    logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_req_rdata,
        output dict1_write_enable, dict1_write_val,
        output dict2_write_enable, dict2_write_val,
        output dict3_write_enable, dict3_write_val
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_req_rdata,
        input  dict1_write_enable, dict1_write_val,
        input  dict2_write_enable, dict2_write_val,
        input  dict3_write_enable, dict3_write_val
    );
endinterface

// File: rtl/dict_loader.sv
// Boot-time loader: reads a dictionary image from memory and streams it into
// the three dictionary write ports while holding the core off.
module dict_loader #(
    parameter int unsigned FIELD1_KEY_WIDTH = 3,
    parameter int unsigned FIELD2_KEY_WIDTH = 5,
    parameter int unsigned FIELD3_KEY_WIDTH = 8,
    parameter int unsigned FIELD1_VAL_WIDTH = 7,
    parameter int unsigned FIELD2_VAL_WIDTH = 10,
    parameter int unsigned FIELD3_VAL_WIDTH = 15,
    parameter logic [31:0] DICT_BASE        = 32'h0000_F000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          core_hold,
    dict_loader_if.master bus
);
    // Wide enough for the unchecked header sum 255 + 255 + 65535.
    localparam int unsigned CNT_W = 17;
    localparam logic [CNT_W-1:0] CAP1 = CNT_W'(2 ** FIELD1_KEY_WIDTH);
    localparam logic [CNT_W-1:0] CAP2 = CNT_W'(2 ** FIELD2_KEY_WIDTH);
    localparam logic [CNT_W-1:0] CAP3 = CNT_W'(2 ** FIELD3_KEY_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_REQ, S_CHECK, S_ENT_REQ, S_WRITE, S_DONE
    } state_t;

    state_t                      state;
    logic [7:0]                  n1;
    logic [7:0]                  n2;
    logic [15:0]                 n3;
    logic [CNT_W-1:0]            idx;
    logic                        req_valid;
    logic [31:0]                 req_addr;
    logic                        wr1_en;
    logic                        wr2_en;
    logic                        wr3_en;
    logic [FIELD1_VAL_WIDTH-1:0] wr1_val;
    logic [FIELD2_VAL_WIDTH-1:0] wr2_val;
    logic [FIELD3_VAL_WIDTH-1:0] wr3_val;

    logic [CNT_W-1:0] lim1_c;
    logic [CNT_W-1:0] lim12_c;
    logic [CNT_W-1:0] total_c;
    logic [CNT_W-1:0] idx_next_c;
    logic             oversize_c;

    // Field boundaries in global entry index space, and header sanity.
    assign lim1_c     = CNT_W'(n1);
    assign lim12_c    = CNT_W'(n1) + CNT_W'(n2);
    assign total_c    = lim12_c + CNT_W'(n3);
    assign idx_next_c = idx + CNT_W'(1);
    assign oversize_c = (CNT_W'(n1) > CAP1) || (CNT_W'(n2) > CAP2) || (CNT_W'(n3) > CAP3);

    // Load sequencer; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            n1        <= '0;
            n2        <= '0;
            n3        <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            req_valid <= 1'b0;
            req_addr  <= '0;
            wr1_en    <= 1'b0;
            wr2_en    <= 1'b0;
            wr3_en    <= 1'b0;
            wr1_val   <= '0;
            wr2_val   <= '0;
            wr3_val   <= '0;
        end else begin
            done   <= 1'b0;
            wr1_en <= 1'b0;
            wr2_en <= 1'b0;
            wr3_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        req_valid <= 1'b1;
                        req_addr  <= DICT_BASE;
                        state     <= S_HDR_REQ;
                    end
                end
                S_HDR_REQ: begin
                    if (bus.mem_req_ready) begin
                        n1        <= bus.mem_req_rdata[7:0];
                        n2        <= bus.mem_req_rdata[15:8];
                        n3        <= bus.mem_req_rdata[31:16];
                        req_valid <= 1'b0;
                        state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (oversize_c) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (total_c == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx       <= '0;
                        req_valid <= 1'b1;
                        req_addr  <= DICT_BASE + 32'd4;
                        state     <= S_ENT_REQ;
                    end
                end
                S_ENT_REQ: begin
                    if (bus.mem_req_ready) begin
                        req_valid <= 1'b0;
                        if (idx < lim1_c) begin
                            wr1_en  <= 1'b1;
                            wr1_val <= bus.mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
                        end else if (idx < lim12_c) begin
                            wr2_en  <= 1'b1;
                            wr2_val <= bus.mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
                        end else begin
                            wr3_en  <= 1'b1;
                            wr3_val <= bus.mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
                        end
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    idx <= idx_next_c;
                    if (idx_next_c < total_c) begin
                        req_valid <= 1'b1;
                        req_addr  <= req_addr + 32'd4;
                        state     <= S_ENT_REQ;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Drive the bus from the registered state.
    assign core_hold              = busy;
    assign bus.mem_req_valid      = req_valid;
    assign bus.mem_req_addr       = req_addr;
    assign bus.dict1_write_enable = wr1_en;
    assign bus.dict1_write_val    = wr1_val;
    assign bus.dict2_write_enable = wr2_en;
    assign bus.dict2_write_val    = wr2_val;
    assign bus.dict3_write_enable = wr3_en;
    assign bus.dict3_write_val    = wr3_val;
endmodule

// File: tb/tb_dict_loader.sv
// Self-checking bench for dict_loader: image memory model, write monitor and
// a reference model of the expected dictionary write stream.
module tb_dict_loader;
    localparam int unsigned K1 = 3;
    localparam int unsigned K2 = 5;
    localparam int unsigned K3 = 8;
    localparam int unsigned V1 = 7;
    localparam int unsigned V2 = 10;
    localparam int unsigned V3 = 15;
    localparam logic [31:0] BASE = 32'h0000_F000;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;
    logic error;
    logic core_hold;

    dict_loader_if #(.FIELD1_VAL_WIDTH(V1), .FIELD2_VAL_WIDTH(V2), .FIELD3_VAL_WIDTH(V3)) bus ();

    dict_loader #(
        .FIELD1_KEY_WIDTH(K1), .FIELD2_KEY_WIDTH(K2), .FIELD3_KEY_WIDTH(K3),
        .FIELD1_VAL_WIDTH(V1), .FIELD2_VAL_WIDTH(V2), .FIELD3_VAL_WIDTH(V3),
        .DICT_BASE(BASE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .error(error), .core_hold(core_hold), .bus(bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Image memory
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Observation state shared between monitor and tests
    int          t0 = 0;
    int          rel;
    bit          mon_on = 1'b0;
    bit          done_seen = 1'b0;
    int          done_cyc = -1;
    logic        err_at_done = 1'b0;
    int          wr_dict[$];
    int          wr_val[$];
    int          wr_cyc[$];
    logic [31:0] hs_addr[$];
    int          hs_wait[$];
    bit          rnd_wait = 1'b0;
    int          fixed_wait = 0;
    int          cur_wait = 0;
    int          wcnt = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int          n_en;

    // Monitor first, then memory responder (ready/rdata change at negedge)
    initial begin : mon_resp
        bus.mem_req_ready = 1'b0;
        bus.mem_req_rdata = 32'h0;
        forever begin
            @(negedge clk);
            rel  = cyc - t0;
            n_en = int'(bus.dict1_write_enable) + int'(bus.dict2_write_enable) + int'(bus.dict3_write_enable);
            chk("one_enable", 32'(n_en <= 1), 32'd1);
            if (!reset) begin
                if (prev_valid && !bus.mem_req_ready) begin
                    chk("req_valid_hold", 32'(bus.mem_req_valid), 32'd1);
                    chk("req_addr_hold", bus.mem_req_addr, prev_addr);
                end
                if (prev_valid && bus.mem_req_ready)
                    chk("req_valid_drop", 32'(bus.mem_req_valid), 32'd0);
            end
            if (bus.dict1_write_enable) begin wr_dict.push_back(1); wr_val.push_back(int'(bus.dict1_write_val)); wr_cyc.push_back(rel); end
            if (bus.dict2_write_enable) begin wr_dict.push_back(2); wr_val.push_back(int'(bus.dict2_write_val)); wr_cyc.push_back(rel); end
            if (bus.dict3_write_enable) begin wr_dict.push_back(3); wr_val.push_back(int'(bus.dict3_write_val)); wr_cyc.push_back(rel); end
            if (mon_on) begin
                if (done) begin
                    chk("busy_at_done", 32'(busy), 32'd0);
                    chk("hold_at_done", 32'(core_hold), 32'd0);
                    done_seen   = 1'b1;
                    done_cyc    = rel;
                    err_at_done = error;
                    mon_on      = 1'b0;
                end else begin
                    chk("busy_in_load", 32'(busy), 32'd1);
                    chk("hold_in_load", 32'(core_hold), 32'd1);
                end
            end
            prev_valid = bus.mem_req_valid;
            prev_addr  = bus.mem_req_addr;
            if (reset || !bus.mem_req_valid) begin
                wcnt = 0;
                bus.mem_req_ready = reset ? 1'b0 : 1'($urandom_range(0, 1));
                bus.mem_req_rdata = $urandom;
            end else if (wcnt >= cur_wait) begin
                bus.mem_req_ready = 1'b1;
                bus.mem_req_rdata = mem_rd(bus.mem_req_addr);
                hs_addr.push_back(bus.mem_req_addr);
                hs_wait.push_back(wcnt);
                wcnt     = 0;
                cur_wait = rnd_wait ? int'($urandom_range(0, 3)) : fixed_wait;
            end else begin
                bus.mem_req_ready = 1'b0;
                bus.mem_req_rdata = $urandom;
                wcnt++;
            end
        end
    end

    task automatic drv_edge();
        @(posedge clk);
        #2;
    endtask

    // Issue start; returns one cycle after start was sampled (load cycle 1)
    task automatic begin_load(input int w);
        wr_dict.delete(); wr_val.delete(); wr_cyc.delete();
        hs_addr.delete(); hs_wait.delete();
        done_seen  = 1'b0;
        done_cyc   = -1;
        rnd_wait   = (w < 0);
        fixed_wait = w;
        cur_wait   = rnd_wait ? int'($urandom_range(0, 3)) : w;
        start = 1'b1;
        t0    = cyc;
        drv_edge();
        start  = 1'b0;
        mon_on = 1'b1;
    endtask

    task automatic finish_load(input int max_cyc);
        int k;
        k = 0;
        while (!done_seen && k < max_cyc) begin
            drv_edge();
            k++;
        end
        chk("load_timeout", 32'(done_seen), 32'd1);
        mon_on = 1'b0;
        drv_edge();
    endtask

    task automatic fill_image(input logic [31:0] hdr);
        int tot;
        mem.delete();
        mem[BASE] = hdr;
        tot = int'(hdr[7:0]) + int'(hdr[15:8]) + int'(hdr[31:16]);
        if (tot > 300) tot = 300;
        for (int i = 0; i < tot; i++) mem[BASE + 32'(4 * (i + 1))] = $urandom;
    endtask

    // Reference model: expected write stream, requests and done time from the image
    task automatic check_load(input int tab_err, input int tab_done, input int w);
        logic [31:0] hdr;
        logic [31:0] word;
        int n1, n2, n3, tot, d, sum;
        bit merr;
        logic [31:0] mask;
        hdr  = mem_rd(BASE);
        n1   = int'(hdr[7:0]);
        n2   = int'(hdr[15:8]);
        n3   = int'(hdr[31:16]);
        merr = (n1 > 8) || (n2 > 32) || (n3 > 256);
        tot  = merr ? 0 : n1 + n2 + n3;
        chk("load_error", 32'(err_at_done), 32'(merr));
        chk("write_count", 32'(wr_dict.size()), 32'(tot));
        for (int i = 0; i < tot && i < wr_dict.size(); i++) begin
            word = mem_rd(BASE + 32'(4 * (i + 1)));
            if (i < n1)           begin d = 1; mask = (32'd1 << V1) - 1; end
            else if (i < n1 + n2) begin d = 2; mask = (32'd1 << V2) - 1; end
            else                  begin d = 3; mask = (32'd1 << V3) - 1; end
            chk("write_dict", 32'(wr_dict[i]), 32'(d));
            chk("write_val", 32'(wr_val[i]), word & mask);
            if (w >= 0) chk("write_cycle", 32'(wr_cyc[i]), 32'(2 + (i + 2) * (w + 1) + i));
        end
        chk("req_count", 32'(hs_addr.size()), 32'(tot + 1));
        for (int i = 0; i < hs_addr.size(); i++)
            chk("req_addr", hs_addr[i], BASE + 32'(4 * i));
        sum = 0;
        foreach (hs_wait[i]) sum += hs_wait[i] + 1;
        chk("done_cycle", 32'(done_cyc), 32'(2 + sum + tot));
        if (tab_done >= 0) chk("done_table", 32'(done_cyc), 32'(tab_done));
        if (tab_err >= 0) begin
            chk("error_table", 32'(err_at_done), 32'(tab_err));
            chk("error_sticky", 32'(error), 32'(tab_err));
        end
    endtask

    typedef struct {
        logic [31:0] hdr;
        int          w;
        int          exp_err;
        int          exp_done;
    } vec_t;

    vec_t vecs[10];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vecs[0] = '{32'h0000_0009, 0, 1, 3};
        vecs[1] = '{32'h0000_2100, 0, 1, 3};
        vecs[2] = '{32'h0101_0000, 0, 1, 3};
        vecs[3] = '{32'h0000_0000, 0, 0, 3};
        vecs[4] = '{32'h0001_2008, 0, 0, 85};
        vecs[5] = '{32'h0000_0500, 0, 0, 13};
        vecs[6] = '{32'h0003_0000, 2, 0, 17};
        vecs[7] = '{32'h0000_0009, 2, 1, 5};
        vecs[8] = '{32'hFFFF_FFFF, 1, 1, 4};
        vecs[9] = '{32'h0100_2008, 0, 0, 595};

        reset = 1'b1;
        start = 1'b0;
        drv_edge();
        drv_edge();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_hold", 32'(core_hold), 32'd0);
        chk("rst_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_addr", bus.mem_req_addr, 32'd0);
        chk("rst_val3", 32'(bus.dict3_write_val), 32'd0);
        drv_edge();
        reset = 1'b0;
        drv_edge();

        // Basic load with masking of upper word bits
        mem.delete();
        mem[BASE] = 32'h0000_0102;
        mem[BASE + 32'd4]  = 32'h1234_5693;
        mem[BASE + 32'd8]  = 32'h0000_00B7;
        mem[BASE + 32'd12] = 32'hFFFF_FEA5;
        begin_load(0);
        finish_load(200);
        check_load(0, 9, 0);
        if (wr_val.size() == 3) begin
            chk("basic_v0", 32'(wr_val[0]), 32'h13);
            chk("basic_v1", 32'(wr_val[1]), 32'h37);
            chk("basic_v2", 32'(wr_val[2]), 32'h2A5);
            chk("basic_c2", 32'(wr_cyc[2]), 32'd8);
        end else chk("basic_writes", 32'(wr_val.size()), 32'd3);

        // Same image with three wait cycles per request
        begin_load(3);
        finish_load(200);
        check_load(0, 21, 3);

        // Table vectors: header limits, empty image, fixed waits
        for (int v = 0; v < 10; v++) begin
            fill_image(vecs[v].hdr);
            begin_load(vecs[v].w);
            finish_load(2000);
            check_load(vecs[v].exp_err, vecs[v].exp_done, vecs[v].w);
        end

        // Full field 3, value equals index
        mem.delete();
        mem[BASE] = 32'h0100_0000;
        for (int i = 0; i < 256; i++) mem[BASE + 32'(4 * (i + 1))] = 32'hABCD_0000 | 32'(i);
        begin_load(0);
        finish_load(2000);
        check_load(0, 515, 0);
        if (hs_addr.size() > 0) chk("f3_last_addr", hs_addr[hs_addr.size() - 1], BASE + 32'h400);
        if (wr_val.size() == 256) chk("f3_last_val", 32'(wr_val[255]), 32'd255);

        // Interrupted load: start while busy ignored, reset after 2nd write
        fill_image(32'h0000_0005);
        begin_load(0);
        drv_edge();
        start = 1'b1;
        drv_edge();
        start = 1'b0;
        for (int k = 0; k < 50 && wr_dict.size() < 2; k++) drv_edge();
        chk("intr_two_writes", 32'(wr_dict.size()), 32'd2);
        if (wr_cyc.size() >= 2) chk("intr_cyc1", 32'(wr_cyc[1]), 32'd6);
        mon_on = 1'b0;
        reset  = 1'b1;
        drv_edge();
        @(negedge clk);
        chk("intr_busy", 32'(busy), 32'd0);
        chk("intr_hold", 32'(core_hold), 32'd0);
        chk("intr_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("intr_addr", bus.mem_req_addr, 32'd0);
        chk("intr_en1", 32'(bus.dict1_write_enable), 32'd0);
        chk("intr_val1", 32'(bus.dict1_write_val), 32'd0);
        drv_edge();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) drv_edge();
        chk("intr_no_more_writes", 32'(wr_dict.size()), 32'd2);
        chk("intr_idle", 32'(busy), 32'd0);
        begin_load(0);
        finish_load(200);
        check_load(0, 13, 0);

        // Randomized images with random memory wait
        for (int r = 0; r < 12; r++) begin
            logic [31:0] hdr;
            hdr[7:0]   = 8'($urandom_range(0, 9));
            hdr[15:8]  = 8'($urandom_range(0, 33));
            hdr[31:16] = ($urandom_range(0, 7) == 0) ? 16'd257 : 16'($urandom_range(0, 40));
            fill_image(hdr);
            begin_load(-1);
            finish_load(2000);
            check_load(-1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dict_loader.md
# dict_loader

Boot-time loader that sits directly upstream of the compression controller's three dictionary write ports. On a `start` pulse it reads a dictionary image from instruction memory at a fixed base address and emits one write pulse per entry into dictionary 1, 2 and 3, in that order. It holds the core off (`core_hold`) until all dictionaries are populated, so no fetch reaches the compressed path with a partially loaded table.

## Interface
- `FIELD1_KEY_WIDTH`, 3, field-1 key width (dictionary 1 capacity is 2^3 = 8)
- `FIELD2_KEY_WIDTH`, 5, field-2 key width (capacity 32)
- `FIELD3_KEY_WIDTH`, 8, field-3 key width (capacity 256)
- `FIELD1_VAL_WIDTH`, 7, field-1 value width
- `FIELD2_VAL_WIDTH`, 10, field-2 value width
- `FIELD3_VAL_WIDTH`, 15, field-3 value width
- `DICT_BASE`, 32'h0000_F000, byte address of the image header word

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: the single clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a load; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until DONE.
- `done` out 1: one-cycle pulse when a load ends, whether successful or in error.
- `error` out 1: header rejected; sticky until the next accepted `start` or `reset`.
- `core_hold` out 1: equals `busy`.
- `mem_req_valid` out 1: memory read request.
- `mem_req_ready` in 1: memory response; `mem_req_rdata` is valid in the same cycle.
- `mem_req_addr` out 32: word-aligned read address.
- `mem_req_rdata` in 32: read data.
- `dict1_write_enable` out 1: write pulse to dictionary 1.
- `dict1_write_val` out `FIELD1_VAL_WIDTH`: value written to dictionary 1.
- `dict2_write_enable` out 1: write pulse to dictionary 2.
- `dict2_write_val` out `FIELD2_VAL_WIDTH`: value written to dictionary 2.
- `dict3_write_enable` out 1: write pulse to dictionary 3.
- `dict3_write_val` out `FIELD3_VAL_WIDTH`: value written to dictionary 3.

## Operation
- **Image format.**
  - Header word at `DICT_BASE`: N1 = [7:0], N2 = [15:8], N3 = [31:16].
  - Entries follow as one word each. Global entry i is at `DICT_BASE + 4*(1+i)`, computed in 32-bit arithmetic that wraps.
  - Order: N1 field-1 entries, then N2 field-2 entries, then N3 field-3 entries.
  - Each entry value is taken from the low VAL_WIDTH bits of its word; upper bits are ignored.
- **States:** IDLE, HDR_REQ, CHECK, ENT_REQ, WRITE, DONE.
- **IDLE.** When `start` is high, clear `error` and go to HDR_REQ.
- **HDR_REQ.** Drive `mem_req_valid` = 1 and `mem_req_addr` = `DICT_BASE`.
  - On `mem_req_ready`, capture N1, N2, N3 and go to CHECK.
- **CHECK.**
  - If N1 > 2^K1, or N2 > 2^K2, or N3 > 2^K3: set `error` and go to DONE. No dictionary writes occur.
  - Else if N1 + N2 + N3 == 0: go to DONE.
  - Else: go to ENT_REQ with entry index 0.
- **ENT_REQ.** Drive `mem_req_valid` = 1 with the entry address.
  - On `mem_req_ready`, register the masked data and the target dictionary, then go to WRITE.
  - Target: index < N1 selects dictionary 1; index < N1+N2 selects dictionary 2; otherwise dictionary 3.
- **WRITE.**
  - Exactly one `dictK_write_enable` is high, with its `dictK_write_val` valid.
  - Increment the index. Go to ENT_REQ if entries remain, else to DONE.
- **DONE.** Pulse `done` for one cycle, then return to IDLE.
- **Write outputs.** Write values are registered and hold their last value between pulses. At most one enable is high in any cycle.
- **Empty fields.** A field with N = 0 is skipped with no cycles spent on it.

## Timing
- **Reset values.**
  - All outputs are 0: `busy`, `done`, `error`, `core_hold`, `mem_req_valid`, `mem_req_addr`, every enable and every value.
  - State returns to IDLE.
- **Reset mid-load.** Applies on the next edge. The load is abandoned and no further writes are issued. Dictionary contents are not touched by this block.
- **Request handshake.**
  - `mem_req_valid` and `mem_req_addr` stay stable until the cycle in which `mem_req_ready` is high.
  - `mem_req_valid` is low in the cycle after that handshake; WRITE and CHECK are never request cycles.
  - `mem_req_ready` while `mem_req_valid` is low is ignored.
- **Latency with zero memory wait** (ready in the first request cycle), with `start` sampled at cycle 0:
  - HDR_REQ at cycle 1, CHECK at cycle 2.
  - Each entry takes 2 cycles.
  - DONE (`done` pulse) at cycle 3 + 2*(N1+N2+N3); `busy` falls in that same cycle.
  - Each wait cycle of memory adds one cycle.
- **`start` handling.** `start` is ignored outside IDLE; a `start` held high re-triggers only after DONE.

## Test plan
- **Basic load.** Header 32'h0000_0102 at `DICT_BASE`, ready tied high, entries 7'h13, 7'h37, 10'h2A5.
  - Writes: dict1 ← 7'h13 at cycle 4, dict1 ← 7'h37 at cycle 6, dict2 ← 10'h2A5 at cycle 8.
  - `done` at cycle 9; no dict3 writes.
- **Oversized header.** Header N1 = 9.
  - `error` = 1 and `done` at cycle 3; no write enables; only one memory request issued.
- **Memory wait.** `mem_req_ready` delayed 3 cycles on every request.
  - `mem_req_valid` and `mem_req_addr` held constant for 4 cycles per request; values written as in the basic load; `done` at cycle 21.
- **Full field 3.** N3 = 256, values equal to the index.
  - 256 dict3 pulses with values 0..255.
  - Last entry read from address `DICT_BASE` + 0x400.
  - `core_hold` high throughout the load.
- **Interrupted load.**
  - `start` re-asserted while busy → ignored.
  - `reset` asserted after the 2nd write → all outputs 0 next cycle, no further writes.
  - A new `start` reloads from the header.
- **Empty image.** Header 0 → `done` at cycle 3 with `error` = 0 and no writes.
